// File: rtl/serial_chunk_adder_pkg.sv
// Shared types and elaboration helpers for the multi-cycle chunked adder/subtractor.
package serial_chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit chunk_fits(input int width, input int chunk);
        return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/serial_chunk_adder_slice.sv
// Combinational CHUNK-bit adder slice; reports the carry into its MSB for overflow detection.
module chunk_adder_slice #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             msb_carry_in
);

    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly.
        msb_carry_in = sum[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
    end

endmodule

// File: rtl/serial_chunk_adder.sv
// WIDTH-bit add/subtract computed CHUNK bits per cycle through one reused slice and a registered carry.
module serial_chunk_adder
    import serial_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_a,
    input  logic [WIDTH-1:0] io_b,
    input  logic             io_cin,
    input  logic             io_sub,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_c,
    output logic             io_cout,
    output logic             io_ovf
);

    localparam int NUM_CHUNKS = num_chunks(WIDTH, CHUNK);
    localparam int CNT_W      = cnt_width(NUM_CHUNKS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHUNKS - 1);

    generate
        if (!chunk_fits(WIDTH, CHUNK)) begin : g_bad_params
            $error("serial_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic               carry_reg;
    logic [WIDTH-1:0]   a_reg, b_reg, res_reg, res_next, c_reg;
    logic               cout_reg, ovf_reg;

    logic [CHUNK-1:0]   slice_sum;
    logic               slice_cout, slice_msb_cin;
    logic               last_chunk;

    chunk_adder_slice #(.CHUNK(CHUNK)) u_slice (
        .a            (a_reg[cnt_reg*CHUNK +: CHUNK]),
        .b            (b_reg[cnt_reg*CHUNK +: CHUNK]),
        .cin          (carry_reg),
        .sum          (slice_sum),
        .cout         (slice_cout),
        .msb_carry_in (slice_msb_cin)
    );

    assign last_chunk = (cnt_reg == LAST);

    // Partial sums build up here so io_c keeps the previous result until the op completes.
    always_comb begin
        res_next = res_reg;
        res_next[cnt_reg*CHUNK +: CHUNK] = slice_sum;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        io_in_ready  = 1'b0;
        io_out_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                io_in_ready = 1'b1;
                if (io_in_valid) state_next = BUSY;
            end
            BUSY: begin
                if (last_chunk) state_next = DONE;
            end
            DONE: begin
                io_out_valid = 1'b1;
                if (io_out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            c_reg     <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (io_in_valid) begin
                        // Subtraction is a + ~b + 1, so invert b and fold the +1 into the carry.
                        a_reg     <= io_a;
                        b_reg     <= io_b ^ {WIDTH{io_sub}};
                        carry_reg <= io_cin ^ io_sub;
                        cnt_reg   <= '0;
                    end
                end
                BUSY: begin
                    res_reg   <= res_next;
                    carry_reg <= slice_cout;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (last_chunk) begin
                        c_reg    <= res_next;
                        cout_reg <= slice_cout;
                        ovf_reg  <= slice_cout ^ slice_msb_cin;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_c    = c_reg;
    assign io_cout = cout_reg;
    assign io_ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Scoreboard bench: directed operations push expected results, a negedge monitor pops and compares.
module tb_serial_chunk_adder;

    localparam int WIDTH = 64;
    localparam int CHUNK = 16;
    localparam int LAT   = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             io_in_valid = 1'b0;
    logic             io_in_ready;
    logic [WIDTH-1:0] io_a = '0;
    logic [WIDTH-1:0] io_b = '0;
    logic             io_cin = 1'b0;
    logic             io_sub = 1'b0;
    logic             io_out_valid;
    logic             io_out_ready = 1'b1;
    logic [WIDTH-1:0] io_c;
    logic             io_cout;
    logic             io_ovf;

    serial_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_a         (io_a),
        .io_b         (io_b),
        .io_cin       (io_cin),
        .io_sub       (io_sub),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_c         (io_c),
        .io_cout      (io_cout),
        .io_ovf       (io_ovf)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [WIDTH-1:0] c;
        logic             cout;
        logic             ovf;
        int               acc;
        string            name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic prev_valid = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic issue(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub, input bit push,
                         input logic [WIDTH-1:0] ec, input logic ecout, input logic eovf);
        int n;
        n = 0;
        @(posedge clock); #1;
        while (!io_in_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (!io_in_ready) check({name, "_in_ready_timeout"}, 64'd0, 64'd1);
        io_a = a; io_b = b; io_cin = cin; io_sub = sub; io_in_valid = 1'b1;
        @(posedge clock); #1;
        io_in_valid = 1'b0;
        if (push) sb.push_back('{ec, ecout, eovf, cyc, name});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !io_in_ready) && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (sb.size() != 0 || !io_in_ready) check("drain_timeout", 64'd0, 64'd1);
    endtask

    // Monitor: latency on each rising out_valid, result compare on each output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev_valid = 1'b0;
            end else begin
                if (io_out_valid && !prev_valid && sb.size() != 0)
                    check({sb[0].name, "_latency"}, 64'(cyc - sb[0].acc), 64'(LAT));
                if (io_out_valid && io_out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_c"}, io_c, e.c);
                        check({e.name, "_cout"}, 64'(io_cout), 64'(e.cout));
                        check({e.name, "_ovf"}, 64'(io_ovf), 64'(e.ovf));
                        $display("txn %s: c=%h cout=%0b ovf=%0b", e.name, io_c, io_cout, io_ovf);
                    end
                end
                prev_valid = io_out_valid;
            end
        end
    end

    initial begin
        int n;
        repeat (2) @(posedge clock);
        #1;
        check("rst_in_ready", 64'(io_in_ready), 64'd1);
        check("rst_out_valid", 64'(io_out_valid), 64'd0);
        check("rst_c", io_c, 64'd0);
        check("rst_cout", 64'(io_cout), 64'd0);
        check("rst_ovf", 64'(io_ovf), 64'd0);
        reset = 1'b1;

        issue("add_wrap",  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1, 64'd0, 1'b1, 1'b0);
        drain();
        issue("add_chunk", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 1, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
        drain();
        issue("add_cin",   64'd0, 64'd0, 1'b1, 1'b0, 1, 64'd1, 1'b0, 1'b0);
        drain();
        issue("sub_5_7",   64'd5, 64'd7, 1'b0, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        drain();
        issue("sub_5_7_b", 64'd5, 64'd7, 1'b1, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
        drain();
        issue("add_ovf",   64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        drain();
        issue("sub_ovf",   64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        drain();

        // Backpressure: result must sit still while operand inputs wiggle.
        io_out_ready = 1'b0;
        issue("bp", 64'h1234, 64'h1111, 1'b0, 1'b0, 1, 64'h2345, 1'b0, 1'b0);
        n = 0;
        @(negedge clock);
        while (!io_out_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!io_out_valid) check("bp_valid_timeout", 64'd0, 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (i == 2) begin
                io_a = 64'hDEAD_BEEF_0000_0000;
                io_b = 64'h0000_0000_CAFE_F00D;
                io_in_valid = 1'b1;
            end
            if (i == 8) io_in_valid = 1'b0;
            @(negedge clock);
            check("bp_out_valid", 64'(io_out_valid), 64'd1);
            check("bp_in_ready", 64'(io_in_ready), 64'd0);
            check("bp_c", io_c, 64'h2345);
            check("bp_cout", 64'(io_cout), 64'd0);
            check("bp_ovf", 64'(io_ovf), 64'd0);
        end
        @(posedge clock); #1;
        io_out_ready = 1'b1;
        @(posedge clock); #1;
        check("bp_release_in_ready", 64'(io_in_ready), 64'd1);
        check("bp_release_out_valid", 64'(io_out_valid), 64'd0);

        // Reset two BUSY cycles into an operation; it must never surface.
        issue("aborted", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0, 0, 64'd0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(io_in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(io_out_valid), 64'd0);
        check("mid_rst_c", io_c, 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        issue("post_rst_add", 64'd3, 64'd4, 1'b0, 1'b0, 1, 64'd7, 1'b0, 1'b0);
        drain();
        repeat (8) @(posedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_chunk_adder.md
Name: serial_chunk_adder

Overview:
- Parametrised successor to the fixed 32-bit inline adder black box.
- Adds or subtracts two WIDTH-bit operands over several cycles, CHUNK bits per cycle, with a registered carry chain.
- Ready/valid handshake on input and output, a subtract mode, and a signed-overflow flag.
- Sits beside datapath blocks that need wide arithmetic without a full-width combinational carry path.

Parameters:
- WIDTH, 64, operand and result width. Must be an exact multiple of CHUNK.
- CHUNK, 16, bits processed per cycle. Must be ≥ 1.
- NUM_CHUNKS, WIDTH/CHUNK, derived and not overridable. Equals the latency in cycles.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_in_valid  in  1  operands valid.
- io_in_ready  out  1  block can accept operands.
- io_a  in  WIDTH  operand A.
- io_b  in  WIDTH  operand B.
- io_cin  in  1  carry-in (borrow-in when subtracting).
- io_sub  in  1  1 = subtract, 0 = add.
- io_out_valid  out  1  result valid.
- io_out_ready  in  1  consumer accepts result.
- io_c  out  WIDTH  sum or difference.
- io_cout  out  1  carry out of the MSB.
- io_ovf  out  1  signed overflow.

Behaviour:
- Reset (reset low, asynchronous):
  - State IDLE, chunk counter 0, carry 0.
  - Operand and result registers 0.
  - Outputs: io_in_ready=1, io_out_valid=0, io_c=0, io_cout=0, io_ovf=0.
  - Reset during BUSY or DONE discards the operation; no partial result is ever presented.
- States: IDLE, BUSY, DONE.
- IDLE:
  - io_in_ready=1.
  - On io_in_valid & io_in_ready: latch io_a, and io_b XOR {WIDTH{io_sub}}; carry <= io_cin XOR io_sub; counter <= 0; go to BUSY.
- BUSY:
  - io_in_ready=0.
  - Each cycle: slice k = a[k] + b'[k] + carry, where k = counter.
  - Write the CHUNK-bit sum into result slice k; carry <= slice carry-out; counter++.
  - When counter == NUM_CHUNKS-1, also capture cout and ovf, then go to DONE.
- DONE:
  - io_out_valid=1. io_c, io_cout and io_ovf are registered and held stable.
  - On io_out_ready: go to IDLE.
  - io_in_ready=0 in DONE; a new operation can be accepted no earlier than the cycle after the output handshake.
- Latency: io_out_valid rises exactly NUM_CHUNKS cycles after the accepting edge. Throughput is one op per NUM_CHUNKS+2 cycles minimum.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - io_cout is the raw carry from the MSB; when subtracting, 1 means no borrow.
  - Subtract with cin=0 gives a−b; with cin=1 it gives a−b−1.
  - io_ovf = carry into MSB XOR carry out of MSB, taken from the final slice.
- Inputs are ignored outside IDLE. Operand changes during BUSY have no effect.
- NUM_CHUNKS=1 is legal: one BUSY cycle.
- Backpressure: DONE may be held indefinitely with all outputs stable.
- Outputs from the previous op remain on io_c, io_cout and io_ovf during IDLE and BUSY, but are qualified only by io_out_valid.

Decomposition:
- Package serial_chunk_adder_pkg:
  - state enum (IDLE, BUSY, DONE);
  - NUM_CHUNKS derivation;
  - counter width = max(1, clog2(NUM_CHUNKS));
  - elaboration-time check that WIDTH % CHUNK == 0.
- Sub-module chunk_adder_slice: combinational CHUNK-bit a+b+cin, producing sum, cout and msb_carry_in (used for ovf). Instantiated once and reused every cycle.

Test Plan (WIDTH=64, CHUNK=16):
- Add a=0xFFFFFFFFFFFFFFFF, b=1, cin=0 -> c=0, cout=1, ovf=0; out_valid exactly 4 cycles after the accept edge.
- Cross-chunk carry: a=0x000000000000FFFF, b=1 -> c=0x0000000000010000, cout=0. Add a=0, b=0, cin=1 -> c=1.
- Subtract a=5, b=7, sub=1, cin=0 -> c=0xFFFFFFFFFFFFFFFE, cout=0, ovf=0. Same with cin=1 -> c=0xFFFFFFFFFFFFFFFD.
- Signed overflow: a=0x7FFFFFFFFFFFFFFF, b=1 add -> c=0x8000000000000000, ovf=1, cout=0. Subtract a=0x8000000000000000, b=1 -> c=0x7FFFFFFFFFFFFFFF, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid, c, cout and ovf stable and in_ready=0. Change io_a and assert in_valid meanwhile -> no effect. Then out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset after 2 BUSY cycles -> in_ready=1 and out_valid=0 immediately, c=0. A following add of 3+4 -> c=7 after 4 cycles.
